// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the RV32I multi-cycle control unit:
// FSM states, opcodes, instruction classes and datapath select codes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_t;

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_LD    = 7'b0000011;
    localparam logic [6:0] OPC_ST    = 7'b0100011;
    localparam logic [6:0] OPC_OPI   = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;

    typedef enum logic [3:0] {
        CL_LUI,
        CL_AUIPC,
        CL_JAL,
        CL_JALR,
        CL_BR,
        CL_LD,
        CL_ST,
        CL_OPI,
        CL_OP
    } iclass_t;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [1:0] WB_MEM = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef struct packed {
        logic    legal;
        iclass_t cls;
    } decode_t;

    // Branches with funct3 010/011 have no RV32I meaning and are rejected.
    function automatic decode_t decode_inst(input logic [6:0] opcode, input logic [2:0] funct3);
        decode_t d;
        d.legal = 1'b1;
        d.cls   = CL_OP;
        case (opcode)
            OPC_LUI:   d.cls = CL_LUI;
            OPC_AUIPC: d.cls = CL_AUIPC;
            OPC_JAL:   d.cls = CL_JAL;
            OPC_JALR:  d.cls = CL_JALR;
            OPC_BR: begin
                d.cls   = CL_BR;
                d.legal = (funct3[2:1] != 2'b01);
            end
            OPC_LD:    d.cls = CL_LD;
            OPC_ST:    d.cls = CL_ST;
            OPC_OPI:   d.cls = CL_OPI;
            OPC_OP:    d.cls = CL_OP;
            default:   d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_dec.sv
// ALU operation decoder: maps instruction class and funct fields to ALUSel.
module alu_dec
    import ctrl_pkg::*;
(
    input  logic [3:0] cls,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] alu_sel
);

    logic is_arith;
    logic alt;

    assign is_arith = (cls == CL_OP) || (cls == CL_OPI);
    // Immediate forms have no SUB; only SRAI carries funct7[5] meaningfully.
    assign alt = funct7_5 && ((cls == CL_OP) || (funct3 == 3'b101));

    always_comb begin
        alu_sel = ALU_ADD;
        if (is_arith) begin
            case (funct3)
                3'b000:  alu_sel = alt ? ALU_SUB : ALU_ADD;
                3'b001:  alu_sel = ALU_SLL;
                3'b010:  alu_sel = ALU_SLT;
                3'b011:  alu_sel = ALU_SLTU;
                3'b100:  alu_sel = ALU_XOR;
                3'b101:  alu_sel = alt ? ALU_SRA : ALU_SRL;
                3'b110:  alu_sel = ALU_OR;
                default: alu_sel = ALU_AND;
            endcase
        end else if (cls == CL_LUI) begin
            alu_sel = ALU_PASSB;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback
// sequencing, memory handshake, illegal-opcode trap and retire counter.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int RESET_PC_WAIT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     inst,
    input  logic            mem_ready,
    input  logic            br_eq,
    input  logic            br_lt,
    output logic            IRWrite,
    output logic            PCWrite,
    output logic            PCSel,
    output logic [2:0]      ImmSel,
    output logic            ASel,
    output logic            BSel,
    output logic [3:0]      ALUSel,
    output logic            BrUn,
    output logic            MemReq,
    output logic            MemRW,
    output logic [1:0]      WBSel,
    output logic            RegWEn,
    output logic            illegal,
    output logic [XLEN-1:0] instret
);

    state_t          state_reg, state_next;
    iclass_t         cls_reg, cls_next;
    logic [3:0]      wait_cnt_reg;
    logic [XLEN-1:0] instret_reg;
    logic            retire;

    logic [2:0] funct3;
    decode_t    dec;
    logic [3:0] alu_sel_dec;
    logic [2:0] imm_cls;
    logic       asel_cls;
    logic       bsel_cls;
    logic       taken;
    logic       unused_inst;

    assign funct3      = inst[14:12];
    assign dec         = decode_inst(inst[6:0], funct3);
    assign unused_inst = ^{inst[31], inst[29:15], inst[11:7]};
    assign instret     = instret_reg;

    alu_dec u_alu_dec (
        .cls      (cls_reg),
        .funct3   (funct3),
        .funct7_5 (inst[30]),
        .alu_sel  (alu_sel_dec)
    );

    always_comb begin
        imm_cls = IMM_I;
        case (cls_reg)
            CL_ST:           imm_cls = IMM_S;
            CL_BR:           imm_cls = IMM_B;
            CL_LUI, CL_AUIPC: imm_cls = IMM_U;
            CL_JAL:          imm_cls = IMM_J;
            default:         imm_cls = IMM_I;
        endcase
    end

    assign asel_cls = (cls_reg == CL_AUIPC) || (cls_reg == CL_JAL) || (cls_reg == CL_BR);
    assign bsel_cls = (cls_reg != CL_OP);
    // funct3[2] picks the less-than comparator, funct3[0] inverts the sense.
    assign taken    = funct3[2] ? (br_lt ^ funct3[0]) : (br_eq ^ funct3[0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_INIT;
            cls_reg      <= CL_OP;
            wait_cnt_reg <= 4'd0;
            instret_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cls_reg   <= cls_next;
            if (state_reg == ST_INIT) begin
                wait_cnt_reg <= wait_cnt_reg + 4'd1;
            end
            if (retire) begin
                instret_reg <= instret_reg + XLEN'(1);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cls_next   = cls_reg;
        retire     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        PCSel      = 1'b0;
        ImmSel     = 3'd0;
        ASel       = 1'b0;
        BSel       = 1'b0;
        ALUSel     = 4'd0;
        BrUn       = 1'b0;
        MemReq     = 1'b0;
        MemRW      = 1'b0;
        WBSel      = 2'd0;
        RegWEn     = 1'b0;
        illegal    = 1'b0;

        // ALU-side selects stay stable from EXEC through WB so the address
        // and result paths do not glitch during the later states.
        if (state_reg == ST_EXEC || state_reg == ST_MEM || state_reg == ST_WB) begin
            ImmSel = imm_cls;
            ASel   = asel_cls;
            BSel   = bsel_cls;
            ALUSel = alu_sel_dec;
        end

        case (state_reg)
            ST_INIT: begin
                if (wait_cnt_reg == 4'(RESET_PC_WAIT - 1)) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                MemReq = 1'b1;
                if (mem_ready) begin
                    IRWrite    = 1'b1;
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                cls_next   = dec.cls;
                state_next = dec.legal ? ST_EXEC : ST_TRAP;
            end
            ST_EXEC: begin
                if (cls_reg == CL_BR) begin
                    BrUn       = funct3[1];
                    PCWrite    = 1'b1;
                    PCSel      = taken;
                    retire     = 1'b1;
                    state_next = ST_FETCH;
                end else if (cls_reg == CL_LD || cls_reg == CL_ST) begin
                    state_next = ST_MEM;
                end else begin
                    state_next = ST_WB;
                end
            end
            ST_MEM: begin
                MemReq = 1'b1;
                MemRW  = (cls_reg == CL_ST);
                if (mem_ready) begin
                    if (cls_reg == CL_ST) begin
                        PCWrite    = 1'b1;
                        retire     = 1'b1;
                        state_next = ST_FETCH;
                    end else begin
                        state_next = ST_WB;
                    end
                end
            end
            ST_WB: begin
                RegWEn = 1'b1;
                if (cls_reg == CL_LD) begin
                    WBSel = WB_MEM;
                end else if (cls_reg == CL_JAL || cls_reg == CL_JALR) begin
                    WBSel = WB_PC4;
                end else begin
                    WBSel = WB_ALU;
                end
                PCWrite    = 1'b1;
                PCSel      = (cls_reg == CL_JAL) || (cls_reg == CL_JALR);
                retire     = 1'b1;
                state_next = ST_FETCH;
            end
            ST_TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl against a per-phase
// behavioural model of the control outputs and retire count.
module tb_multicycle_ctrl;

    localparam int WAIT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst = 32'h0000_0013;
    logic        mem_ready = 1'b0;
    logic        br_eq = 1'b0;
    logic        br_lt = 1'b0;
    logic        IRWrite, PCWrite, PCSel, ASel, BSel, BrUn, MemReq, MemRW, RegWEn, illegal;
    logic [2:0]  ImmSel;
    logic [3:0]  ALUSel;
    logic [1:0]  WBSel;
    logic [31:0] instret;

    always #5 clk = ~clk;

    multicycle_ctrl #(.XLEN(32), .RESET_PC_WAIT(WAIT)) dut (
        .clk(clk), .rst(rst), .inst(inst), .mem_ready(mem_ready),
        .br_eq(br_eq), .br_lt(br_lt), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCSel(PCSel), .ImmSel(ImmSel), .ASel(ASel), .BSel(BSel),
        .ALUSel(ALUSel), .BrUn(BrUn), .MemReq(MemReq), .MemRW(MemRW),
        .WBSel(WBSel), .RegWEn(RegWEn), .illegal(illegal), .instret(instret)
    );

    logic [18:0] obs;
    assign obs = {IRWrite, PCWrite, PCSel, ImmSel, ASel, BSel, ALUSel, BrUn,
                  MemReq, MemRW, WBSel, RegWEn, illegal};

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_txn = 0;
    int unsigned model_ret = 0;

    typedef enum {P_INIT, P_FETCH, P_DECODE, P_EXEC, P_MEM, P_WB, P_TRAP} phase_t;
    typedef enum {K_LUI, K_AUIPC, K_JAL, K_JALR, K_BR, K_LD, K_ST, K_OPI, K_OP, K_BAD} kind_t;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic kind_t classify(input logic [31:0] ins);
        case (ins[6:0])
            7'b0110111: return K_LUI;
            7'b0010111: return K_AUIPC;
            7'b1101111: return K_JAL;
            7'b1100111: return K_JALR;
            7'b1100011: return (ins[14:13] == 2'b01) ? K_BAD : K_BR;
            7'b0000011: return K_LD;
            7'b0100011: return K_ST;
            7'b0010011: return K_OPI;
            7'b0110011: return K_OP;
            default:    return K_BAD;
        endcase
    endfunction

    function automatic logic [3:0] alu_code(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0: return alt ? 4'd1 : 4'd0;
            3'd1: return 4'd2;
            3'd2: return 4'd3;
            3'd3: return 4'd4;
            3'd4: return 4'd5;
            3'd5: return alt ? 4'd7 : 4'd6;
            3'd6: return 4'd8;
            default: return 4'd9;
        endcase
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic eq, input logic lt);
        case (f3)
            3'b000: return eq;
            3'b001: return !eq;
            3'b100, 3'b110: return lt;
            default: return !lt;
        endcase
    endfunction

    function automatic logic [18:0] exp_ctrl(input phase_t ph, input logic [31:0] ins,
                                             input logic rdy, input logic eq, input logic lt);
        kind_t      k;
        logic [2:0] f3;
        logic       irw, pcw, pcs, asel, bsel, brun, mreq, mrw, regw, ill;
        logic [2:0] imm;
        logic [3:0] alu;
        logic [1:0] wbs;
        k = classify(ins);
        f3 = ins[14:12];
        irw = 0; pcw = 0; pcs = 0; asel = 0; bsel = 0; brun = 0;
        mreq = 0; mrw = 0; regw = 0; ill = 0; imm = 0; alu = 0; wbs = 0;
        if (ph == P_EXEC || ph == P_MEM || ph == P_WB) begin
            case (k)
                K_ST: imm = 3'd1;
                K_BR: imm = 3'd2;
                K_LUI, K_AUIPC: imm = 3'd3;
                K_JAL: imm = 3'd4;
                default: imm = 3'd0;
            endcase
            asel = (k == K_AUIPC || k == K_JAL || k == K_BR);
            bsel = (k != K_OP);
            if (k == K_OP) alu = alu_code(f3, ins[30]);
            else if (k == K_OPI) alu = alu_code(f3, ins[30] && f3 == 3'b101);
            else if (k == K_LUI) alu = 4'd10;
        end
        case (ph)
            P_FETCH: begin
                mreq = 1;
                irw = rdy;
            end
            P_EXEC: if (k == K_BR) begin
                brun = f3[1];
                pcw = 1;
                pcs = branch_taken(f3, eq, lt);
            end
            P_MEM: begin
                mreq = 1;
                mrw = (k == K_ST);
                pcw = (k == K_ST) && rdy;
            end
            P_WB: begin
                regw = 1;
                wbs = (k == K_LD) ? 2'd0 : (k == K_JAL || k == K_JALR) ? 2'd2 : 2'd1;
                pcw = 1;
                pcs = (k == K_JAL || k == K_JALR);
            end
            P_TRAP: ill = 1;
            default: ;
        endcase
        return {irw, pcw, pcs, imm, asel, bsel, alu, brun, mreq, mrw, wbs, regw, ill};
    endfunction

    // One clock cycle: drive inputs just after the edge, check, advance.
    task automatic step(input phase_t ph, input logic [31:0] ins, input logic rdy,
                        input logic eq, input logic lt, input string tag);
        inst = ins;
        mem_ready = rdy;
        br_eq = eq;
        br_lt = lt;
        #1;
        check_eq(tag, {45'd0, obs}, {45'd0, exp_ctrl(ph, ins, rdy, eq, lt)});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = rb();
        #1;
        check_eq("rst_ctrl", {45'd0, obs}, 64'd0);
        check_eq("rst_instret", {32'd0, instret}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_ret = 0;
        for (int i = 0; i < WAIT; i++) step(P_INIT, 32'h13, rb(), rb(), rb(), "init");
    endtask

    task automatic run_instr(input logic [31:0] ins, input int fdelay, input int mdelay,
                             input logic eq, input logic lt);
        kind_t k;
        k = classify(ins);
        for (int i = 0; i < fdelay; i++) step(P_FETCH, ins, 1'b0, rb(), rb(), "fetch_wait");
        step(P_FETCH, ins, 1'b1, rb(), rb(), "fetch");
        step(P_DECODE, ins, rb(), rb(), rb(), "decode");
        if (k == K_BAD) begin
            n_txn++;
            $display("txn %0d inst=0x%08h kind=%s -> trap", n_txn, ins, k.name());
            return;
        end
        step(P_EXEC, ins, rb(), eq, lt, "exec");
        if (k == K_LD || k == K_ST) begin
            for (int i = 0; i < mdelay; i++) step(P_MEM, ins, 1'b0, rb(), rb(), "mem_wait");
            step(P_MEM, ins, 1'b1, rb(), rb(), "mem");
        end
        if (k != K_BR && k != K_ST) step(P_WB, ins, rb(), rb(), rb(), "wb");
        model_ret++;
        check_eq("instret", {32'd0, instret}, {32'd0, model_ret});
        n_txn++;
        $display("txn %0d inst=0x%08h kind=%s fdly=%0d mdly=%0d instret=%0d",
                 n_txn, ins, k.name(), fdelay, mdelay, instret);
    endtask

    task automatic run_trap(input logic [31:0] ins);
        run_instr(ins, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(P_TRAP, ins, rb(), rb(), rb(), "trap");
        check_eq("trap_instret", {32'd0, instret}, {32'd0, model_ret});
        do_reset();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [6:0]  opc [9];
        opc = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
        r = $urandom;
        r[6:0] = opc[$urandom_range(0, 8)];
        if (r[6:0] == 7'b1100011 && r[14:13] == 2'b01) r[14] = 1'b1;
        return r;
    endfunction

    initial begin
        #1;
        do_reset();
        // Directed cases
        run_instr(32'h002081B3, 0, 0, 1'b0, 1'b0);             // ADD x3,x1,x2
        run_instr(32'h00209463, 0, 0, 1'b0, 1'b0);             // BNE, not equal -> taken
        run_instr(32'h00209463, 0, 0, 1'b1, 1'b0);             // BNE, equal -> not taken
        run_instr(32'h0000A183, 0, 3, 1'b0, 1'b0);             // LW, 3 wait cycles in MEM
        run_instr(32'h0030A223, 1, 1, 1'b0, 1'b0);             // SW
        run_instr(32'h008000EF, 0, 0, 1'b0, 1'b0);             // JAL
        run_instr(32'h4020D193, 0, 0, 1'b0, 1'b0);             // SRAI
        run_instr(32'h40208033, 0, 0, 1'b0, 1'b0);             // SUB
        run_instr(32'h40008013, 0, 0, 1'b0, 1'b0);             // ADDI with bit30 set
        run_instr(32'h12345037, 0, 0, 1'b0, 1'b0);             // LUI
        // Randomized stream
        for (int n = 0; n < 80; n++) begin
            run_instr(rand_inst(), $urandom_range(0, 2), $urandom_range(0, 3), rb(), rb());
        end
        // Illegal opcode: trap, then reset clears it
        run_trap(32'h0000007F);
        // Branch with reserved funct3
        run_trap(32'h0020B063);
        // Reset asserted mid-FETCH
        inst = 32'h002081B3;
        mem_ready = 1'b0;
        #1;
        check_eq("fetch_pre_rst", {45'd0, obs}, {45'd0, exp_ctrl(P_FETCH, inst, 1'b0, 1'b0, 1'b0)});
        #2;
        do_reset();
        run_instr(32'h002081B3, 0, 0, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
